// File: rtl/gen_arb_grnt_mux.sv
// Requester-side companion to a round-robin arbiter: raises requests, locks onto the
// granted client for a whole packet and forwards it through a registered valid/ready stage.
module gen_arb_grnt_mux #(
    parameter  int WID     = 16,
    parameter  int DAT_WID = 32,
    localparam int SRC_WID = (WID > 1) ? $clog2(WID) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WID-1:0]         in_vld,
    input  logic [WID*DAT_WID-1:0] in_dat,
    input  logic [WID-1:0]         in_lst,
    output logic [WID-1:0]         in_rdy,
    output logic [WID-1:0]         rqsts,
    input  logic [WID-1:0]         grnts,
    output logic                   out_vld,
    output logic [DAT_WID-1:0]     out_dat,
    output logic                   out_lst,
    output logic [SRC_WID-1:0]     out_src,
    input  logic                   out_rdy,
    output logic                   err_grnt
);

    typedef enum logic {IDLE, LOCK} state_e;

    state_e               state_q, state_d;
    logic [WID-1:0]       lck_q, lck_d;
    logic [SRC_WID-1:0]   lck_src_q, lck_src_d;
    logic                 out_vld_q, out_vld_d;
    logic [DAT_WID-1:0]   out_dat_q, out_dat_d;
    logic                 out_lst_q, out_lst_d;
    logic [SRC_WID-1:0]   out_src_q, out_src_d;
    logic                 err_grnt_q, err_grnt_d;

    logic                 grnt_one_hot;
    logic                 grnt_legal;
    logic                 grnt_bad;
    logic [SRC_WID-1:0]   grnt_idx;
    logic [DAT_WID-1:0]   sel_dat;
    logic                 sel_lst;
    logic                 accept;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lck_q      <= '0;
            lck_src_q  <= '0;
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            out_lst_q  <= 1'b0;
            out_src_q  <= '0;
            err_grnt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lck_q      <= lck_d;
            lck_src_q  <= lck_src_d;
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            out_lst_q  <= out_lst_d;
            out_src_q  <= out_src_d;
            err_grnt_q <= err_grnt_d;
        end
    end

    // Grant decode and the one-hot AND-OR select of the locked client's beat.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        grnt_one_hot = (grnts != '0) && ((grnts & (grnts - WID'(1))) == '0);
        grnt_legal   = grnt_one_hot && ((grnts & in_vld) != '0);
        grnt_bad     = (grnts != '0) && !grnt_legal;
        grnt_idx     = '0;
        sel_dat      = '0;
        sel_lst      = 1'b0;
        for (int i = 0; i < WID; i++) begin
            if (grnts[i]) grnt_idx = SRC_WID'(i);
            if (lck_q[i]) begin
                sel_dat = sel_dat | in_dat[i*DAT_WID +: DAT_WID];
                sel_lst = sel_lst | in_lst[i];
            end
        end
    end

    // Output decode: requests only while idle, ready only for the locked client.
    always_comb begin
        rqsts  = '0;
        in_rdy = '0;
        if (state_q == IDLE) rqsts = in_vld;
        else                 in_rdy = lck_q & {WID{~out_vld_q | out_rdy}};
    end

    assign accept = |(in_vld & in_rdy);

    always_comb begin
        state_d    = state_q;
        lck_d      = lck_q;
        lck_src_d  = lck_src_q;
        err_grnt_d = err_grnt_q;
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        out_lst_d  = out_lst_q;
        out_src_d  = out_src_q;

        case (state_q)
            IDLE: begin
                if (grnt_legal) begin
                    state_d   = LOCK;
                    lck_d     = grnts;
                    lck_src_d = grnt_idx;
                end else if (grnt_bad) begin
                    err_grnt_d = 1'b1;
                end
            end
            LOCK: begin
                if (accept && sel_lst) begin
                    state_d = IDLE;
                    lck_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new accept overrides the drain, so the stage streams 1 beat/cycle.
        if (accept) begin
            out_vld_d = 1'b1;
            out_dat_d = sel_dat;
            out_lst_d = sel_lst;
            out_src_d = lck_src_q;
        end else if (out_vld_q && out_rdy) begin
            out_vld_d = 1'b0;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_dat  = out_dat_q;
    assign out_lst  = out_lst_q;
    assign out_src  = out_src_q;
    assign err_grnt = err_grnt_q;

endmodule

// File: tb/tb_gen_arb_grnt_mux.sv
// Directed bench for gen_arb_grnt_mux (WID=4, DAT_WID=8) with a behavioural round-robin
// arbiter and per-client packet sources advanced on observed handshakes.
module tb_gen_arb_grnt_mux;

    localparam int WID = 4;
    localparam int DW  = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [WID-1:0]  in_vld, in_lst, in_rdy, rqsts, grnts;
    logic [WID*DW-1:0] in_dat;
    logic            out_vld, out_lst, out_rdy, err_grnt;
    logic [DW-1:0]   out_dat;
    logic [1:0]      out_src;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] src_dat [WID][16];
    logic          src_lst [WID][16];
    int            src_n [WID];
    int            src_p [WID];

    int            rr_ptr = 3;
    logic [WID-1:0] rr_gnt;
    logic [WID-1:0] gnt_ovr = '0;
    logic           gnt_ovr_en = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        rr_gnt = '0;
        for (int k = 1; k <= WID; k++)
            if (rr_gnt == '0 && rqsts[(rr_ptr + k) % WID]) rr_gnt[(rr_ptr + k) % WID] = 1'b1;
    end

    assign grnts = gnt_ovr_en ? gnt_ovr : rr_gnt;

    gen_arb_grnt_mux #(.WID(WID), .DAT_WID(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .in_dat   (in_dat),
        .in_lst   (in_lst),
        .in_rdy   (in_rdy),
        .rqsts    (rqsts),
        .grnts    (grnts),
        .out_vld  (out_vld),
        .out_dat  (out_dat),
        .out_lst  (out_lst),
        .out_src  (out_src),
        .out_rdy  (out_rdy),
        .err_grnt (err_grnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [1:0] s,
                             input logic [DW-1:0] d, input logic l);
        check({tag, "_vld"}, 32'(out_vld), 32'(v));
        if (v) begin
            check({tag, "_src"}, 32'(out_src), 32'(s));
            check({tag, "_dat"}, 32'(out_dat), 32'(d));
            check({tag, "_lst"}, 32'(out_lst), 32'(l));
        end
    endtask

    task automatic drive_srcs();
        for (int c = 0; c < WID; c++) begin
            if (src_p[c] < src_n[c]) begin
                in_vld[c]          = 1'b1;
                in_dat[c*DW +: DW] = src_dat[c][src_p[c]];
                in_lst[c]          = src_lst[c][src_p[c]];
            end else begin
                in_vld[c]          = 1'b0;
                in_dat[c*DW +: DW] = '0;
                in_lst[c]          = 1'b0;
            end
        end
    endtask

    task automatic push(input int c, input logic [DW-1:0] d, input logic l);
        src_dat[c][src_n[c]] = d;
        src_lst[c][src_n[c]] = l;
        src_n[c]++;
    endtask

    task automatic clear_srcs();
        for (int c = 0; c < WID; c++) begin
            src_n[c] = 0;
            src_p[c] = 0;
        end
        drive_srcs();
    endtask

    // One clock: sample handshakes and grant mid-cycle, then advance sources after the edge.
    task automatic tick();
        logic [WID-1:0] fire, g;
        @(negedge clk);
        fire = in_vld & in_rdy & {WID{rst_n}};
        g    = grnts;
        @(posedge clk);
        #1;
        for (int c = 0; c < WID; c++) if (fire[c]) src_p[c]++;
        if (!rst_n) rr_ptr = 3;
        else if (!gnt_ovr_en) begin
            for (int k = 0; k < WID; k++) if (g[k]) rr_ptr = k;
        end
        drive_srcs();
        #1;
    endtask

    task automatic do_reset();
        clear_srcs();
        gnt_ovr_en = 1'b0;
        out_rdy    = 1'b1;
        rst_n      = 1'b0;
        tick();
        rst_n      = 1'b1;
    endtask

    task automatic load_pkt_a();
        push(2, 8'hA0, 1'b0);
        push(2, 8'hA1, 1'b0);
        push(2, 8'hA2, 1'b1);
        drive_srcs();
        #1;
    endtask

    initial begin
        logic [DW-1:0] sb_dat [6];
        logic [1:0]    ct_src [12];
        logic [DW-1:0] ct_dat [12];
        logic          ct_vld [12];
        logic          ct_lst [12];

        in_vld = '0; in_lst = '0; in_dat = '0; out_rdy = 1'b1; rst_n = 1'b0;
        clear_srcs();
        tick();
        do_reset();

        // Reset state
        check("rst_out_vld", 32'(out_vld), 32'h0);
        check("rst_out_dat", 32'(out_dat), 32'h0);
        check("rst_out_lst", 32'(out_lst), 32'h0);
        check("rst_out_src", 32'(out_src), 32'h0);
        check("rst_err",     32'(err_grnt), 32'h0);
        check("rst_in_rdy",  32'(in_rdy), 32'h0);
        check("rst_rqsts",   32'(rqsts), 32'h0);

        // Single packet from client 2
        load_pkt_a();
        check("sp_rqsts_c0", 32'(rqsts), 32'h4);
        tick();
        check("sp_rqsts_c1", 32'(rqsts), 32'h0);
        check("sp_in_rdy_c1", 32'(in_rdy), 32'h4);
        check_out("sp_c1", 1'b0, 2'd0, 8'h00, 1'b0);
        tick();
        check("sp_rqsts_c2", 32'(rqsts), 32'h0);
        check_out("sp_c2", 1'b1, 2'd2, 8'hA0, 1'b0);
        tick();
        check("sp_rqsts_c3", 32'(rqsts), 32'h0);
        check_out("sp_c3", 1'b1, 2'd2, 8'hA1, 1'b0);
        tick();
        check_out("sp_c4", 1'b1, 2'd2, 8'hA2, 1'b1);
        tick();
        check_out("sp_c5", 1'b0, 2'd0, 8'h00, 1'b0);

        // Back-pressure: out_rdy low in cycles 2-4
        do_reset();
        load_pkt_a();
        tick();
        check("bp_in_rdy_c1", 32'(in_rdy), 32'h4);
        tick();
        out_rdy = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            check_out("bp_hold", 1'b1, 2'd2, 8'hA0, 1'b0);
            check("bp_in_rdy_hold", 32'(in_rdy), 32'h0);
        end
        tick();
        out_rdy = 1'b1;
        #1;
        check_out("bp_c5", 1'b1, 2'd2, 8'hA0, 1'b0);
        check("bp_in_rdy_c5", 32'(in_rdy), 32'h4);
        tick();
        check_out("bp_c6", 1'b1, 2'd2, 8'hA1, 1'b0);
        tick();
        check_out("bp_c7", 1'b1, 2'd2, 8'hA2, 1'b1);
        tick();
        check_out("bp_c8", 1'b0, 2'd0, 8'h00, 1'b0);

        // Single-beat packets from client 1: one beat every 2 cycles
        do_reset();
        push(1, 8'h51, 1'b1);
        push(1, 8'h52, 1'b1);
        push(1, 8'h53, 1'b1);
        drive_srcs();
        #1;
        sb_dat = '{8'h51, 8'h00, 8'h52, 8'h00, 8'h53, 8'h00};
        tick();
        for (int k = 0; k < 6; k++) begin
            tick();
            check_out("sb", (k % 2) == 0, 2'd1, sb_dat[k], 1'b1);
        end

        // Contention between clients 0 and 3, two 2-beat packets each
        do_reset();
        push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b1); push(0, 8'h12, 1'b0); push(0, 8'h13, 1'b1);
        push(3, 8'h30, 1'b0); push(3, 8'h31, 1'b1); push(3, 8'h32, 1'b0); push(3, 8'h33, 1'b1);
        drive_srcs();
        #1;
        check("ct_rqsts_c0", 32'(rqsts), 32'h9);
        ct_vld = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        ct_src = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd0};
        ct_dat = '{8'h10, 8'h11, 8'h00, 8'h30, 8'h31, 8'h00, 8'h12, 8'h13, 8'h00, 8'h32, 8'h33, 8'h00};
        ct_lst = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tick();
        for (int k = 0; k < 12; k++) begin
            tick();
            check_out("ct", ct_vld[k], ct_src[k], ct_dat[k], ct_lst[k]);
        end

        // Reset in the middle of a packet
        do_reset();
        load_pkt_a();
        tick();
        tick();
        check_out("rm_c2", 1'b1, 2'd2, 8'hA0, 1'b0);
        rst_n = 1'b0;
        tick();
        check("rm_out_vld", 32'(out_vld), 32'h0);
        check("rm_in_rdy",  32'(in_rdy), 32'h0);
        check("rm_out_src", 32'(out_src), 32'h0);
        check("rm_rqsts",   32'(rqsts), 32'h4);
        rst_n = 1'b1;
        #1;
        tick();
        check("rm_in_rdy_relock", 32'(in_rdy), 32'h4);
        tick();
        check_out("rm_c5", 1'b1, 2'd2, 8'hA1, 1'b0);
        tick();
        check_out("rm_c6", 1'b1, 2'd2, 8'hA2, 1'b1);

        // Illegal grant: two bits set
        do_reset();
        push(0, 8'h01, 1'b1);
        push(1, 8'h02, 1'b1);
        gnt_ovr    = 4'b0011;
        gnt_ovr_en = 1'b1;
        drive_srcs();
        #1;
        check("ig1_err_c0", 32'(err_grnt), 32'h0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("ig1_err",    32'(err_grnt), 32'h1);
            check("ig1_in_rdy", 32'(in_rdy), 32'h0);
            check("ig1_rqsts",  32'(rqsts), 32'h3);
        end

        // Illegal grant: client 3 granted while its valid is low
        do_reset();
        push(0, 8'h01, 1'b1);
        gnt_ovr    = 4'b1000;
        gnt_ovr_en = 1'b1;
        drive_srcs();
        #1;
        check("ig2_err_c0", 32'(err_grnt), 32'h0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("ig2_err",    32'(err_grnt), 32'h1);
            check("ig2_in_rdy", 32'(in_rdy), 32'h0);
            check("ig2_rqsts",  32'(rqsts), 32'h1);
        end
        gnt_ovr_en = 1'b0;
        #1;
        tick();
        check("ig2_err_sticky", 32'(err_grnt), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
